// File: rtl/ctrl_defs.sv
// Shared definitions for the multicycle controller: state encoding,
// instruction classes, opcode constants and datapath select codes.
package ctrl_defs;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  typedef enum logic [2:0] {
    CL_R   = 3'd0,
    CL_MEM = 3'd1,
    CL_I   = 3'd2,
    CL_BR  = 3'd3,
    CL_J   = 3'd4,
    CL_ILL = 3'd5
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LOGIC = 2'b11;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier.
//   opcode_i   : instruction bits [31:26]
//   iclass_o   : instruction class (CL_ILL for unsupported opcodes)
//   is_store_o : memory class op is sw
//   ext_sel_o  : 1 = sign-extend imm16, 0 = zero-extend (andi/ori)
module ctrl_decode
  import ctrl_defs::*;
(
  input  logic [5:0] opcode_i,
  output iclass_e    iclass_o,
  output logic       is_store_o,
  output logic       ext_sel_o
);

  always_comb begin
    iclass_o   = CL_ILL;
    is_store_o = 1'b0;
    ext_sel_o  = 1'b1;
    case (opcode_i)
      OP_RTYPE: iclass_o = CL_R;
      OP_LW:    iclass_o = CL_MEM;
      OP_SW: begin
        iclass_o   = CL_MEM;
        is_store_o = 1'b1;
      end
      OP_ADDI:  iclass_o = CL_I;
      OP_ANDI, OP_ORI: begin
        iclass_o  = CL_I;
        ext_sel_o = 1'b0;
      end
      OP_BEQ:   iclass_o = CL_BR;
      OP_J:     iclass_o = CL_J;
      default:  iclass_o = CL_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM (Moore, except the memory-gated
// enables in FETCH/MEM_WR and the DECODE illegal pulse).
//   clk, rst_n       : clock, async active-low reset
//   opcode           : IR[31:26], sampled and held from DECODE onwards
//   mem_ready        : memory access completes in the cycle it is high
//   pc_write .. reg_write, branch : write/access enables
//   ext_sel, iord, reg_dst, mem_to_reg, alu_src_a/b, alu_op, pc_src : selects
//   retire           : pulse in final cycle of each instruction
//   illegal          : pulse in DECODE for unsupported opcodes
module multicycle_ctrl
  import ctrl_defs::*;
#(
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       branch,
  output logic       ext_sel,
  output logic       iord,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       retire,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic [5:0] opc_q;
  logic [5:0] dec_opc;
  iclass_e    dec_class;
  logic       dec_store;
  logic       dec_ext;
  logic       mem_done;

  // One decoder serves both uses: live opcode while in DECODE, the
  // captured copy afterwards so input changes cannot disturb the instruction.
  assign dec_opc  = (state_q == S_DECODE) ? opcode : opc_q;
  assign mem_done = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  ctrl_decode u_dec (
    .opcode_i   (dec_opc),
    .iclass_o   (dec_class),
    .is_store_o (dec_store),
    .ext_sel_o  (dec_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) opc_q <= opcode;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    branch     = 1'b0;
    ext_sel    = 1'b1;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOP_ADD;
    pc_src     = PCSRC_ALU;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        // rst_n gate keeps IR/PC writes quiet while reset holds us here.
        ir_write  = mem_done & rst_n;
        pc_write  = mem_done & rst_n;
        if (mem_done) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (dec_class)
          CL_R:    state_d = S_R_EXEC;
          CL_MEM:  state_d = S_MEM_ADDR;
          CL_I:    state_d = S_I_EXEC;
          CL_BR:   state_d = S_BRANCH;
          CL_J:    state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = dec_store ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_done) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_done) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_sel   = dec_ext;
        // Zero-extended immediates are exactly the logical ops.
        alu_op    = dec_ext ? ALUOP_ADD : ALUOP_LOGIC;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        ext_sel   = dec_ext;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        pc_src    = PCSRC_ALUOUT;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_HANDSHAKE, default 1, meaning: 1 = memory states wait for mem_ready; 0 = memory completes in one cycle (mem_ready ignored).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 opcode  input  6  instruction bits [31:26] from instruction register.
REQ-005 mem_ready  input  1  memory handshake: access completes in the cycle it is high.
REQ-006 pc_write, ir_write, mem_read, mem_write, reg_write  output  1 each  datapath write/access enables.
REQ-007 branch  output  1  conditional PC write; PC loads only when ALU zero is also high (gated outside this block).
REQ-008 ext_sel  output  1  sign-extender mode: 1 = sign-extend imm16, 0 = zero-extend.
REQ-009 iord, reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath mux selects.
REQ-010 alu_src_b  output  2  00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2.
REQ-011 alu_op  output  2  00 add, 01 sub, 10 funct-decode, 11 logic-from-opcode.
REQ-012 pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-013 retire  output  1  one-cycle pulse in the final cycle of each instruction.
REQ-014 illegal  output  1  one-cycle pulse when DECODE sees an unsupported opcode.

Function
REQ-015 Moore FSM; states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP; every output is a function of state only, except retire and mem-gated enables as stated below.
REQ-016 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write and pc_write high only in the cycle the access completes; advance to DECODE on completion, otherwise hold.
REQ-017 DECODE: alu_src_b=11, ext_sel=1 (branch target precompute); next state by opcode: 000000 R_EXEC, 100011/101011 MEM_ADDR, 001000/001100/001101 I_EXEC, 000100 BRANCH, 000010 JUMP, any other -> FETCH with illegal=1.
REQ-018 MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_sel=1, alu_op=00; lw -> MEM_RD, sw -> MEM_WR.
REQ-019 MEM_RD: mem_read=1, iord=1; hold until completion then MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, retire=1 -> FETCH.
REQ-020 MEM_WR: mem_write=1, iord=1; hold until completion; retire=1 in completion cycle -> FETCH.
REQ-021 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, retire=1 -> FETCH.
REQ-022 I_EXEC: alu_src_a=1, alu_src_b=10; addi: ext_sel=1, alu_op=00; andi/ori: ext_sel=0, alu_op=11 -> I_WB. I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, ext_sel as in I_EXEC, retire=1 -> FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, branch=1, pc_src=01, retire=1 -> FETCH. JUMP: pc_write=1, pc_src=10, retire=1 -> FETCH.
REQ-024 Opcode is registered in DECODE and the registered copy steers MEM_ADDR/I_EXEC/I_WB, so later opcode input changes have no effect mid-instruction.
REQ-025 With MEM_HANDSHAKE=1, mem_read/mem_write stay asserted for the whole wait; ir_write/pc_write/retire assert only in the mem_ready cycle.
REQ-026 Outputs not listed for a state are 0; ext_sel defaults to 1.

Reset
REQ-027 rst_n low forces state FETCH and all outputs to their FETCH values with ir_write=pc_write=0, immediately and asynchronously, including mid-wait or mid-instruction; no retire or illegal pulse is generated.
REQ-028 First fetch access begins in the first clk edge after rst_n deasserts.

Structure
REQ-029 Opcode constants, state encoding (4-bit), alu_op and alu_src_b codes live in shared package ctrl_defs.
REQ-030 One sub-module: ctrl_decode (combinational opcode -> class/legal/ext_sel); FSM stays in multicycle_ctrl.

Verification
REQ-031 lw (100011), mem_ready always 1 -> states FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB; 5 cycles; one retire in MEM_WB; reg_write=1, mem_to_reg=1.
REQ-032 ori (001101) -> I_EXEC and I_WB show ext_sel=0, alu_op=11; addi (001000) same path shows ext_sel=1, alu_op=00; 4 cycles each.
REQ-033 sw with mem_ready low 3 cycles in MEM_WR -> mem_write high 4 cycles, retire only in 4th, no reg_write.
REQ-034 Opcode 111111 -> illegal pulse in DECODE, next state FETCH, no retire, no write enables.
REQ-035 rst_n pulsed low during MEM_RD wait -> outputs revert to FETCH values without clk edge; no retire; normal fetch after release.
REQ-036 beq then j back-to-back -> 3 cycles each; branch=1, alu_op=01 in BRANCH; pc_write=1, pc_src=10 in JUMP.
